// File: rtl/arbiter_8_1.sv
// 8-requester round-robin arbiter with a one-hot grant, binary select for the
// shared datapath mux, per-requester completion pulse and a BUSY watchdog.
module arbiter_8_1 #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic [7:0] in_req,
  input  logic       in_ack,
  output logic [7:0] out_grant,
  output logic [2:0] out_sel,
  output logic       out_valid,
  output logic [7:0] out_done,
  output logic       out_timeout
);

  localparam int          N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned REQ_W = 8;

  // Counter value seen on the last permitted BUSY cycle; unused when TIMEOUT is 0.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [REQ_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic [REQ_W-1:0]     done_q, done_d;
  logic                 timeout_q, timeout_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;

  // Round-robin search: first set request at ptr, ptr+1, ... (mod 8).
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_q + IDX_W'(k);
      if (in_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and output decode; done/timeout default low so they pulse once.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    done_d    = '0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = REQ_W'(1) << win_idx;
          sel_d   = win_idx;
          valid_d = 1'b1;
          ptr_d   = win_idx + IDX_W'(1);
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (in_ack) begin
          // Ack takes priority over a watchdog expiry on the same edge.
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          done_d  = REQ_W'(1) << sel_q;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          grant_d   = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_grant   = grant_q;
  assign out_sel     = sel_q;
  assign out_valid   = valid_q;
  assign out_done    = done_q;
  assign out_timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_8_1.sv
// Bench for arbiter_8_1: one instance with a 4-cycle watchdog, one with the
// watchdog disabled, both fed the same inputs and checked against a model.
module tb_arbiter_8_1;

  logic       in_clk;
  logic       in_rst_n;
  logic [7:0] in_req;
  logic       in_ack;

  logic [7:0] grant_a, done_a, grant_b, done_b;
  logic [2:0] sel_a, sel_b;
  logic       valid_a, tmo_a, valid_b, tmo_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = TIMEOUT 4, index 1 = TIMEOUT 0.
  int         m_tmo [2] = '{4, 0};
  bit         m_busy[2];
  int         m_ptr [2];
  int         m_age [2];
  int         m_sel [2];
  logic [7:0] m_done[2];
  bit         m_to  [2];

  arbiter_8_1 #(.TIMEOUT(4), .CNT_WIDTH(3)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_req(in_req), .in_ack(in_ack),
    .out_grant(grant_a), .out_sel(sel_a), .out_valid(valid_a),
    .out_done(done_a), .out_timeout(tmo_a)
  );

  arbiter_8_1 #(.TIMEOUT(0), .CNT_WIDTH(2)) dut_nt (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_req(in_req), .in_ack(in_ack),
    .out_grant(grant_b), .out_sel(sel_b), .out_valid(valid_b),
    .out_done(done_b), .out_timeout(tmo_b)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Behavioural model: one transaction at a time, age = BUSY cycles elapsed.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (!in_rst_n) begin
        m_busy[c] = 0; m_ptr[c] = 0; m_age[c] = 0; m_sel[c] = 0;
        m_done[c] = '0; m_to[c] = 0;
      end else begin
        m_done[c] = '0;
        m_to[c]   = 0;
        if (!m_busy[c]) begin
          if (in_req != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
              if (in_req[(m_ptr[c] + k) % 8]) begin
                m_sel[c] = (m_ptr[c] + k) % 8;
                break;
              end
            end
            m_busy[c] = 1;
            m_ptr[c]  = (m_sel[c] + 1) % 8;
            m_age[c]  = 0;
          end
        end else begin
          m_age[c] = m_age[c] + 1;
          if (in_ack) begin
            m_busy[c] = 0;
            m_done[c] = 8'd1 << m_sel[c];
          end else if (m_tmo[c] > 0 && m_age[c] == m_tmo[c]) begin
            m_busy[c] = 0;
            m_to[c]   = 1;
          end
        end
      end
    end
  endtask

  // Advance one clock; outputs are then observed at the falling edge.
  task automatic tick();
    @(posedge in_clk);
    model_step();
    @(negedge in_clk);
  endtask

  task automatic do_reset();
    in_rst_n = 1'b0; in_req = 8'h00; in_ack = 1'b0;
    tick();
    in_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_rst_n = 1'b0; in_req = 8'hFF; in_ack = 1'b1;
    tick(); tick();
    n_checks++; if ({grant_a, sel_a, valid_a, done_a, tmo_a} !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs_a: got %h required 0", {grant_a, sel_a, valid_a, done_a, tmo_a}); end
    n_checks++; if ({grant_b, sel_b, valid_b, done_b, tmo_b} !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs_b: got %h required 0", {grant_b, sel_b, valid_b, done_b, tmo_b}); end
    in_rst_n = 1'b1; in_req = 8'h00; in_ack = 1'b0;
    tick();
    n_checks++; if (valid_a !== 1'b0 || grant_a !== 8'h00) begin
      n_fail++; $display("FAIL reset_idle: valid %b grant %h required 0/00", valid_a, grant_a); end
  endtask

  task automatic test_single();
    do_reset();
    in_req = 8'h01;
    tick();
    n_checks++; if (grant_a !== 8'h01 || sel_a !== 3'd0) begin
      n_fail++; $display("FAIL single_grant: grant %h sel %0d required 01/0", grant_a, sel_a); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (valid_a !== 1'b1 || valid_b !== 1'b1) begin
        n_fail++; $display("FAIL single_valid cycle %0d: got %b/%b required 1", i, valid_a, valid_b); end
      if (i < 2) tick();
    end
    in_ack = 1'b1; in_req = 8'h00;
    tick();
    n_checks++; if (done_a !== 8'h01 || done_b !== 8'h01) begin
      n_fail++; $display("FAIL single_done: got %h/%h required 01", done_a, done_b); end
    n_checks++; if (valid_a !== 1'b0 || grant_a !== 8'h00 || tmo_a !== 1'b0) begin
      n_fail++; $display("FAIL single_release: valid %b grant %h tmo %b required 0", valid_a, grant_a, tmo_a); end
    in_ack = 1'b0;
    tick();
    n_checks++; if (done_a !== 8'h00) begin
      n_fail++; $display("FAIL single_done_pulse: got %h required 00", done_a); end
    n_checks++; if (sel_a !== 3'd0) begin
      n_fail++; $display("FAIL single_sel_hold: got %0d required 0", sel_a); end
  endtask

  task automatic test_round_robin();
    do_reset();
    in_req = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      n_checks++; if (sel_a !== 3'(n % 8) || grant_a !== (8'd1 << (n % 8)) || sel_b !== 3'(n % 8)) begin
        n_fail++; $display("FAIL rr_grant %0d: sel %0d/%0d grant %h required %0d", n, sel_a, sel_b, grant_a, n % 8); end
      in_ack = 1'b1;
      tick();
      n_checks++; if (valid_a !== 1'b0 || done_a !== (8'd1 << (n % 8))) begin
        n_fail++; $display("FAIL rr_idle %0d: valid %b done %h required 0/%h", n, valid_a, done_a, 8'd1 << (n % 8)); end
      in_ack = 1'b0;
      tick();
    end
    in_ack = 1'b1; in_req = 8'h00;
    tick();
    in_ack = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    in_req = 8'h20;
    tick();
    n_checks++; if (sel_a !== 3'd5) begin
      n_fail++; $display("FAIL wrap_first: sel %0d required 5", sel_a); end
    in_ack = 1'b1; in_req = 8'h00;
    tick();
    in_ack = 1'b0; in_req = 8'h81;
    tick();
    n_checks++; if (sel_a !== 3'd7 || grant_a !== 8'h80) begin
      n_fail++; $display("FAIL wrap_to7: sel %0d grant %h required 7/80", sel_a, grant_a); end
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    tick();
    n_checks++; if (sel_a !== 3'd0 || grant_a !== 8'h01) begin
      n_fail++; $display("FAIL wrap_to0: sel %0d grant %h required 0/01", sel_a, grant_a); end
    in_ack = 1'b1; in_req = 8'h00;
    tick();
    in_ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    in_req = 8'h04;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (valid_a !== 1'b1 || sel_a !== 3'd2 || tmo_a !== 1'b0) begin
        n_fail++; $display("FAIL tmo_busy cycle %0d: valid %b sel %0d tmo %b required 1/2/0", i, valid_a, sel_a, tmo_a); end
      if (i == 3) in_req = 8'h0C;
      tick();
    end
    n_checks++; if (tmo_a !== 1'b1 || done_a !== 8'h00 || valid_a !== 1'b0 || grant_a !== 8'h00) begin
      n_fail++; $display("FAIL tmo_pulse: tmo %b done %h valid %b grant %h required 1/00/0/00", tmo_a, done_a, valid_a, grant_a); end
    n_checks++; if (valid_b !== 1'b1 || tmo_b !== 1'b0 || sel_b !== 3'd2) begin
      n_fail++; $display("FAIL no_watchdog_hold: valid %b tmo %b sel %0d required 1/0/2", valid_b, tmo_b, sel_b); end
    tick();
    n_checks++; if (sel_a !== 3'd3 || tmo_a !== 1'b0) begin
      n_fail++; $display("FAIL tmo_next_search: sel %0d tmo %b required 3/0", sel_a, tmo_a); end
    in_ack = 1'b1; in_req = 8'h00;
    tick();
    n_checks++; if (done_a !== 8'h08 || done_b !== 8'h04 || tmo_b !== 1'b0) begin
      n_fail++; $display("FAIL tmo_after_ack: done %h/%h tmo_b %b required 08/04/0", done_a, done_b, tmo_b); end
    in_ack = 1'b0;
    tick();
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    in_req = 8'h04;
    tick(); tick(); tick(); tick();
    in_ack = 1'b1; in_req = 8'h00;
    tick();
    n_checks++; if (done_a !== 8'h04 || tmo_a !== 1'b0) begin
      n_fail++; $display("FAIL ack_wins: done %h tmo %b required 04/0", done_a, tmo_a); end
    tick();
    n_checks++; if (done_a !== 8'h00 || valid_a !== 1'b0) begin
      n_fail++; $display("FAIL ack_idle_ignored: done %h valid %b required 00/0", done_a, valid_a); end
    in_ack = 1'b0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    in_req = 8'hFF;
    tick();
    in_req = 8'h00;
    tick(); tick();
    in_rst_n = 1'b0; in_req = 8'h81; in_ack = 1'b1;
    tick();
    n_checks++; if ({grant_a, sel_a, valid_a, done_a, tmo_a} !== 21'd0) begin
      n_fail++; $display("FAIL reset_busy_abort: got %h required 0", {grant_a, sel_a, valid_a, done_a, tmo_a}); end
    in_rst_n = 1'b1; in_ack = 1'b0;
    tick();
    n_checks++; if (sel_a !== 3'd0 || grant_a !== 8'h01 || done_a !== 8'h00) begin
      n_fail++; $display("FAIL reset_busy_regrant: sel %0d grant %h done %h required 0/01/00", sel_a, grant_a, done_a); end
    in_ack = 1'b1; in_req = 8'h00;
    tick();
    in_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] g, d, eg;
    logic [2:0] s;
    logic       v, t;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_rst_n = ($urandom_range(0, 199) != 0);
      in_req   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      in_ack   = ($urandom_range(0, 3) == 0);
      tick();
      for (int c = 0; c < 2; c++) begin
        g = (c == 0) ? grant_a : grant_b;
        s = (c == 0) ? sel_a   : sel_b;
        v = (c == 0) ? valid_a : valid_b;
        d = (c == 0) ? done_a  : done_b;
        t = (c == 0) ? tmo_a   : tmo_b;
        eg = m_busy[c] ? (8'd1 << m_sel[c]) : 8'h00;
        n_checks++; if (g !== eg) begin
          n_fail++; $display("FAIL rand_grant dut%0d cyc %0d: got %h required %h", c, cyc, g, eg); end
        n_checks++; if (s !== 3'(m_sel[c])) begin
          n_fail++; $display("FAIL rand_sel dut%0d cyc %0d: got %0d required %0d", c, cyc, s, m_sel[c]); end
        n_checks++; if (v !== m_busy[c]) begin
          n_fail++; $display("FAIL rand_valid dut%0d cyc %0d: got %b required %b", c, cyc, v, m_busy[c]); end
        n_checks++; if (d !== m_done[c]) begin
          n_fail++; $display("FAIL rand_done dut%0d cyc %0d: got %h required %h", c, cyc, d, m_done[c]); end
        n_checks++; if (t !== m_to[c]) begin
          n_fail++; $display("FAIL rand_timeout dut%0d cyc %0d: got %b required %b", c, cyc, t, m_to[c]); end
      end
    end
  endtask

  initial begin
    in_rst_n = 1'b0; in_req = 8'h00; in_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_ack_at_timeout();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
